// File: rtl/hworld_reg_pkg.sv
// Byte offsets of the hworld register file as seen on its OBI port.
package hworld_reg_pkg;

  localparam logic [31:0] HWORLD_A_OFF    = 32'h0;
  localparam logic [31:0] HWORLD_B_OFF    = 32'h4;
  localparam logic [31:0] HWORLD_SUM_OFF  = 32'h8;
  localparam logic [31:0] HWORLD_COUT_OFF = 32'hC;

endpackage

// File: rtl/hworld_seq_pkg.sv
// Sequencer states, access phases and default register offsets for hworld_obi_seq.
package hworld_seq_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_A    = 3'd1,
    WR_B    = 3'd2,
    RD_SUM  = 3'd3,
    RD_COUT = 3'd4,
    RESP    = 3'd5
  } seq_state_e;

  typedef enum logic {
    ADDR = 1'b0,
    DATA = 1'b1
  } seq_phase_e;

  localparam logic [31:0] SEQ_A_OFF    = hworld_reg_pkg::HWORLD_A_OFF;
  localparam logic [31:0] SEQ_B_OFF    = hworld_reg_pkg::HWORLD_B_OFF;
  localparam logic [31:0] SEQ_SUM_OFF  = hworld_reg_pkg::HWORLD_SUM_OFF;
  localparam logic [31:0] SEQ_COUT_OFF = hworld_reg_pkg::HWORLD_COUT_OFF;

  function automatic logic is_write(seq_state_e s);
    return (s == WR_A) || (s == WR_B);
  endfunction

  // The fixed access order; the last read hands over to RESP.
  function automatic seq_state_e next_access(seq_state_e s);
    case (s)
      WR_A:    return WR_B;
      WR_B:    return RD_SUM;
      RD_SUM:  return RD_COUT;
      default: return RESP;
    endcase
  endfunction

endpackage

// File: rtl/obi_pkg.sv
// OBI request/response channel types shared by bus masters and slaves.
package obi_pkg;

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage

// File: rtl/hworld_seq_wdog.sv
// Per-phase stall watchdog: counts enabled cycles since the last clear and
// flags expiry in the TIMEOUT-th cycle of a phase.
module hworld_seq_wdog #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired_o = en_i && (cnt_q >= LIMIT);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/hworld_obi_seq.sv
// OBI master that writes an operand pair into hworld, reads SUM/COUT back and
// returns them on a result stream; one transaction outstanding at a time.
module hworld_obi_seq
  import obi_pkg::*;
  import hworld_seq_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter logic [31:0] A_OFF     = SEQ_A_OFF,
  parameter logic [31:0] B_OFF     = SEQ_B_OFF,
  parameter logic [31:0] SUM_OFF   = SEQ_SUM_OFF,
  parameter logic [31:0] COUT_OFF  = SEQ_COUT_OFF,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        op_valid_i,
  output logic        op_ready_o,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  output logic        res_valid_o,
  input  logic        res_ready_i,
  output logic [31:0] res_sum_o,
  output logic        res_cout_o,
  output logic        res_err_o,
  output logic        busy_o,
  output obi_req_t    reg_req_o,
  input  obi_resp_t   reg_rsp_i
);

  seq_state_e  state_q, state_d;
  seq_phase_e  phase_q, phase_d;
  logic [31:0] op_a_q, op_a_d;
  logic [31:0] op_b_q, op_b_d;
  logic [31:0] sum_q, sum_d;
  logic        cout_q, cout_d;
  logic        err_q, err_d;
  obi_req_t    req_q, req_d;
  logic        wdog_clr, wdog_en, wdog_expired;
  logic        abort;

  // Request fields for the ADDR phase of access state s; held until gnt.
  function automatic obi_req_t build_req(seq_state_e s, logic [31:0] a, logic [31:0] b);
    obi_req_t r;
    r       = '0;
    r.req   = 1'b1;
    r.be    = 4'hF;
    r.we    = is_write(s);
    case (s)
      WR_A:    begin r.addr = BASE_ADDR + A_OFF;   r.wdata = a; end
      WR_B:    begin r.addr = BASE_ADDR + B_OFF;   r.wdata = b; end
      RD_SUM:  r.addr = BASE_ADDR + SUM_OFF;
      default: r.addr = BASE_ADDR + COUT_OFF;
    endcase
    return r;
  endfunction

  hworld_seq_wdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wdog (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (wdog_clr),
    .en_i     (wdog_en),
    .expired_o(wdog_expired)
  );

  // Watchdog restarts on every phase change; a stall in either phase aborts to RESP with err.
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    err_d    = err_q;
    req_d    = req_q;
    wdog_clr = 1'b0;
    abort    = 1'b0;
    wdog_en  = (state_q != IDLE) && (state_q != RESP);

    case (state_q)
      IDLE: begin
        wdog_clr = 1'b1;
        if (op_valid_i) begin
          op_a_d  = op_a_i;
          op_b_d  = op_b_i;
          sum_d   = '0;
          cout_d  = 1'b0;
          err_d   = 1'b0;
          state_d = WR_A;
          phase_d = ADDR;
          req_d   = build_req(WR_A, op_a_d, op_b_d);
        end
      end
      RESP: begin
        wdog_clr = 1'b1;
        if (res_ready_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        if (phase_q == ADDR) begin
          if (reg_rsp_i.gnt) begin
            req_d    = '0;
            phase_d  = DATA;
            wdog_clr = 1'b1;
          end else if (wdog_expired) begin
            abort = 1'b1;
          end
        end else begin
          if (reg_rsp_i.rvalid) begin
            wdog_clr = 1'b1;
            if (state_q == RD_SUM) begin
              sum_d = reg_rsp_i.rdata;
            end
            if (state_q == RD_COUT) begin
              cout_d = reg_rsp_i.rdata[0];
            end
            state_d = next_access(state_q);
            phase_d = ADDR;
            if (state_q != RD_COUT) begin
              req_d = build_req(next_access(state_q), op_a_q, op_b_q);
            end
          end else if (wdog_expired) begin
            abort = 1'b1;
          end
        end
        if (abort) begin
          req_d    = '0;
          sum_d    = '0;
          cout_d   = 1'b0;
          err_d    = 1'b1;
          state_d  = RESP;
          phase_d  = ADDR;
          wdog_clr = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      phase_q <= ADDR;
      op_a_q  <= '0;
      op_b_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      err_q   <= err_d;
      req_q   <= req_d;
    end
  end

  assign op_ready_o  = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign res_valid_o = (state_q == RESP);
  assign res_sum_o   = sum_q;
  assign res_cout_o  = cout_q;
  assign res_err_o   = err_q;
  assign reg_req_o   = req_q;

endmodule
